// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order buffering, redirect flush.
// Optional FQ_BYPASS_EN: an empty queue forwards a fresh response straight to decode.
module fetch_queue #(
   parameter int          W        = 64,
   parameter int          IW       = 32,
   parameter int          DEPTH    = 4,
   parameter logic [W-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [W-1:0]  imem_addr,
   input  logic          imem_rvalid,
   input  logic [IW-1:0] imem_rdata,
   input  logic          redirect,
   input  logic [W-1:0]  redirect_pc,
   output logic          instr_valid,
   output logic [IW-1:0] instr_o,
   output logic [W-1:0]  pc_o,
   input  logic          instr_ready
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  r_fetch_pc;
   logic [W-1:0]  r_resp_pc;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop_cnt;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [IW-1:0] r_q_instr [DEPTH];
   logic [W-1:0]  r_q_pc    [DEPTH];

   logic [CW:0]   w_occ;
   logic          w_issue;
   logic          w_empty;
   logic          w_rsp;
   logic          w_drop;
   logic          w_accept;
   logic          w_byp;
   logic          w_push;
   logic          w_pop;

   // Valid/ready: the head transfers on a rising edge where instr_valid and instr_ready are both high
   // and no redirect is present; imem_req is a fire-and-forget request the memory always accepts.
   always_comb begin
      w_occ    = {1'b0, r_count} + {1'b0, r_inflight};
      // Queued entries plus outstanding requests never exceed DEPTH, so a push always has room.
      w_issue  = rst && !redirect && (w_occ < (CW+1)'(DEPTH));
      w_empty  = (r_count == '0);
      w_rsp    = imem_rvalid && (r_inflight != '0);
      w_drop   = w_rsp && (r_drop_cnt != '0);
      w_accept = w_rsp && !w_drop && !redirect;
`ifdef FQ_BYPASS_EN
      w_byp    = w_accept && w_empty;
`else
      w_byp    = 1'b0;
`endif
      instr_valid = !w_empty || w_byp;
      instr_o     = '0;
      pc_o        = '0;
      if (!w_empty) begin
         instr_o = r_q_instr[r_rd_ptr];
         pc_o    = r_q_pc[r_rd_ptr];
      end else if (w_byp) begin
         instr_o = imem_rdata;
         pc_o    = r_resp_pc;
      end
      w_pop     = !w_empty && instr_ready && !redirect;
      w_push    = w_accept && !(w_byp && instr_ready);
      imem_req  = w_issue;
      imem_addr = r_fetch_pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_issue) - CW'(w_rsp);
         if (redirect) begin
            r_fetch_pc <= redirect_pc & ~W'(3);
            r_resp_pc  <= redirect_pc & ~W'(3);
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            // Everything still outstanding after this cycle belongs to the old path.
            r_drop_cnt <= r_inflight - CW'(w_rsp);
         end else begin
            if (w_issue)  r_fetch_pc <= r_fetch_pc + W'(4);
            if (w_accept) r_resp_pc  <= r_resp_pc + W'(4);
            if (w_drop)   r_drop_cnt <= r_drop_cnt - CW'(1);
            if (w_push)   r_wr_ptr   <= r_wr_ptr + PW'(1);
            if (w_pop)    r_rd_ptr   <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_instr[r_wr_ptr] <= imem_rdata;
         r_q_pc[r_wr_ptr]    <= r_resp_pc;
      end
   end

   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst) imem_rvalid |-> (r_inflight != '0));
   a_drop_bound:    assert property (@(posedge clk) disable iff (!rst) r_drop_cnt <= r_inflight);
   a_credit:        assert property (@(posedge clk) disable iff (!rst) w_occ <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with selectable latency,
// expected-PC scoreboard checked by an independent pop monitor.
module tb_fetch_queue;
   localparam int W  = 64;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req;
   logic [W-1:0]  imem_addr;
   logic          imem_rvalid;
   logic [IW-1:0] imem_rdata;
   logic          redirect;
   logic [W-1:0]  redirect_pc;
   logic          instr_valid;
   logic [IW-1:0] instr_o;
   logic [W-1:0]  pc_o;
   logic          instr_ready;

   fetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_o     (instr_o),
      .pc_o        (pc_o),
      .instr_ready (instr_ready)
   );

   always #5 clk = ~clk;

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   int           rel_cyc  = 0;
   int           first_valid = -1;
   int           lat      = 1;
   int           req_cnt  = 0;
   int           n_run    = 0;
   logic [W-1:0] exp_fetch;
   logic         s_valid, s_rvalid, s_req;
   logic [W-1:0] s_addr;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mem_addr_q[$];
   int           mem_due_q[$];

   function automatic logic [IW-1:0] instr_of(input logic [W-1:0] a);
      return a[31:0] ^ 32'hA5A5_5A5A;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input logic rdy, input logic redir, input logic [W-1:0] tgt);
      instr_ready = rdy;
      redirect    = redir;
      redirect_pc = tgt;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (mem_due_q.size() != 0 && mem_due_q[0] == cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = instr_of(mem_addr_q[0]);
         void'(mem_due_q.pop_front());
         void'(mem_addr_q.pop_front());
      end
      #1;
      s_valid  = instr_valid;
      s_rvalid = imem_rvalid;
      s_req    = imem_req;
      s_addr   = imem_addr;
      if (first_valid < 0 && instr_valid) first_valid = cyc - rel_cyc;
      if (redir) begin
         chk("redirect_no_issue", {63'd0, imem_req}, 64'd0);
         exp_fetch = tgt & ~64'd3;
      end else if (imem_req) begin
         chk("req_addr", imem_addr, exp_fetch);
         mem_addr_q.push_back(imem_addr);
         mem_due_q.push_back(cyc + lat);
         exp_fetch = exp_fetch + 64'd4;
         req_cnt++;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_empty(output int n);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         cycle(1'b1, 1'b0, '0);
         n++;
      end
      chk("pops_complete", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic drain();
      int k;
      k = 0;
      do begin
         cycle(1'b0, 1'b0, '0);
         k++;
      end while ((mem_due_q.size() != 0 || s_req) && k < 40);
      chk("drain", 64'(mem_due_q.size()) + 64'(s_req), 64'd0);
   endtask

   task automatic push_seq(input logic [W-1:0] base, input int num);
      for (int i = 0; i < num; i++) exp_q.push_back(base + 64'(4 * i));
   endtask

   // Pop monitor: a transfer happens at the next rising edge when valid, ready and no redirect.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pop actual_pc=0x%0h required=no_pop", pc_o);
            end else begin
               e = exp_q.pop_front();
               chk("pop_pc", pc_o, e);
               chk("pop_instr", 64'(instr_o), 64'(instr_of(e)));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      exp_fetch = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req",   {63'd0, imem_req}, 64'd0);
      chk("rst_valid", {63'd0, instr_valid}, 64'd0);
      chk("rst_instr", 64'(instr_o), 64'd0);
      chk("rst_pc",    pc_o, 64'd0);

      // Latency-1 stream from reset, decode always ready.
      @(negedge clk);
      rst = 1'b1;
      rel_cyc = cyc;
      push_seq(64'h0, 16);
      run_until_empty(n_run);
`ifdef FQ_BYPASS_EN
      chk("first_valid_cycle", 64'(first_valid), 64'd1);
      chk("stream_cycles", 64'(n_run), 64'd17);
`else
      chk("first_valid_cycle", 64'(first_valid), 64'd2);
      chk("stream_cycles", 64'(n_run), 64'd18);
`endif

      // Decode stalled: exactly DEPTH requests, then fetch stops.
      drain();
      cycle(1'b0, 1'b1, 64'h400);
      req_cnt = 0;
      repeat (10) cycle(1'b0, 1'b0, '0);
      chk("stall_req_count", 64'(req_cnt), 64'd4);
      chk("stall_req_low",   {63'd0, s_req}, 64'd0);
      chk("stall_valid",     {63'd0, s_valid}, 64'd1);
      push_seq(64'h400, 8);
      run_until_empty(n_run);

      // Latency-3 memory, three requests in flight, redirect drops all of them.
      drain();
      lat = 3;
      cycle(1'b0, 1'b1, 64'h800);
      repeat (3) cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b1, 64'h100);
      chk("redir_with_rsp", {63'd0, s_rvalid}, 64'd1);
      push_seq(64'h100, 8);
      run_until_empty(n_run);

      // Unaligned redirect target.
      drain();
      lat = 1;
      cycle(1'b0, 1'b1, 64'h203);
      cycle(1'b1, 1'b0, '0);
      chk("align_req",  {63'd0, s_req}, 64'd1);
      chk("align_addr", s_addr, 64'h200);
      push_seq(64'h200, 4);
      run_until_empty(n_run);

      // Redirect coinciding with a response and a would-be pop.
      cycle(1'b1, 1'b1, 64'h300);
      chk("coincide_rvalid", {63'd0, s_rvalid}, 64'd1);
`ifndef FQ_BYPASS_EN
      chk("coincide_valid", {63'd0, s_valid}, 64'd1);
`endif
      cycle(1'b1, 1'b0, '0);
      chk("flush_empty", {63'd0, s_valid}, 64'd0);
      push_seq(64'h300, 4);
      run_until_empty(n_run);
      push_seq(64'h310, 4);
      run_until_empty(n_run);

      // Asynchronous reset in the middle of a cycle with work outstanding.
      instr_ready = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      chk("async_req",   {63'd0, imem_req}, 64'd0);
      chk("async_valid", {63'd0, instr_valid}, 64'd0);
      chk("async_instr", 64'(instr_o), 64'd0);
      chk("async_pc",    pc_o, 64'd0);
      mem_due_q.delete();
      mem_addr_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_fetch = '0;
      push_seq(64'h0, 8);
      run_until_empty(n_run);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
